axi_ic_b: RTL and testbench



---
 rtl/axi_ic_pkg.sv | 21 ++
 rtl/axi_b_if.sv | 12 +
 rtl/axi_ic_b_route.sv | 73 +++++++
 rtl/demux.sv | 16 +
 rtl/mux.sv | 17 +
 rtl/pipeline_skid_buffer.sv | 43 ++++
 rtl/rr_arbiter.sv | 34 +++
 rtl/axi_ic_b.sv | 89 ++++++++
 tb/tb_axi_ic_b.sv | 251 +++++++++++++++++++++++++
 9 files changed

// File: rtl/axi_ic_pkg.sv
// Shared AXI interconnect definitions: ID split constants, BRESP encodings and B payload.
package axi_ic_pkg;

    localparam int unsigned ID_W_WIDTH = 8;
    localparam int unsigned ID_W_HALF  = ID_W_WIDTH / 2;

    typedef enum logic [1:0] {
        BRESP_OKAY   = 2'b00,
        BRESP_EXOKAY = 2'b01,
        BRESP_SLVERR = 2'b10,
        BRESP_DECERR = 2'b11
    } bresp_e;

    typedef struct packed {
        logic [1:0]            bresp;
        logic [ID_W_WIDTH-1:0] bid;
    } b_payload_t;

    localparam int unsigned B_PAYLOAD_W = $bits(b_payload_t);

endpackage

// File: rtl/axi_b_if.sv
// AXI write-response channel bundle; master modport is the interconnect's slave-facing side.
interface axi_b_if;
    import axi_ic_pkg::*;

    logic                  bvalid;
    logic                  bready;
    logic [ID_W_WIDTH-1:0] bid;
    logic [1:0]            bresp;

    modport master (input bvalid, input bid, input bresp, output bready);
    modport slave  (output bvalid, output bid, output bresp, input bready);
endinterface

// File: rtl/axi_ic_b_route.sv
// Per-master B path: arbitrates requesting slaves, holds the grant while stalled, returns ready.
module axi_ic_b_route
    import axi_ic_pkg::*;
#(
    parameter int unsigned NumSlaves  = 2,
    parameter int unsigned GrantWidth = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NumSlaves-1:0]   req,
    input  logic [B_PAYLOAD_W-1:0] data [NumSlaves],
    output logic                   bvalid,
    output logic [ID_W_WIDTH-1:0]  bid,
    output logic [1:0]             bresp,
    input  logic                   bready,
    output logic [NumSlaves-1:0]   ready,
    output logic [GrantWidth-1:0]  grant
);
    logic                   arb_valid;
    logic [GrantWidth-1:0]  arb_idx;
    logic [GrantWidth-1:0]  sel;
    logic                   locked_q;
    logic [GrantWidth-1:0]  lock_sel_q;
    logic                   valid_c;
    logic                   fire_c;
    logic [B_PAYLOAD_W-1:0] sel_data;
    b_payload_t             sel_pl;

    rr_arbiter #(.Width(NumSlaves)) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .upd         (fire_c),
        .upd_idx     (sel),
        .grant_valid (arb_valid),
        .grant_idx   (arb_idx)
    );

    assign sel     = locked_q ? lock_sel_q : arb_idx;
    assign valid_c = locked_q ? req[lock_sel_q] : arb_valid;
    assign fire_c  = valid_c && bready;

    mux #(.Width(B_PAYLOAD_W), .Num(NumSlaves)) u_mux (
        .data (data),
        .sel  (sel),
        .y    (sel_data)
    );

    assign sel_pl = b_payload_t'(sel_data);
    assign bvalid = valid_c;
    assign bid    = valid_c ? sel_pl.bid : '0;
    assign bresp  = valid_c ? sel_pl.bresp : '0;
    assign grant  = sel;

    demux #(.Num(NumSlaves)) u_demux (
        .value (fire_c),
        .sel   (sel),
        .y     (ready)
    );

    // An offered-but-unaccepted response pins the grant until its handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_q   <= 1'b0;
            lock_sel_q <= '0;
        end else if (valid_c && !bready) begin
            locked_q   <= 1'b1;
            lock_sel_q <= sel;
        end else if (fire_c) begin
            locked_q   <= 1'b0;
        end
    end
endmodule

// File: rtl/demux.sv
// Binary-select 1:N single-bit demultiplexer.
module demux #(
    parameter  int unsigned Num  = 2,
    localparam int unsigned SelW = (Num > 1) ? $clog2(Num) : 1
) (
    input  logic            value,
    input  logic [SelW-1:0] sel,
    output logic [Num-1:0]  y
);
    always_comb begin
        y = '0;
        for (int unsigned i = 0; i < Num; i++) begin
            y[i] = value && (sel == SelW'(i));
        end
    end
endmodule

// File: rtl/mux.sv
// Binary-select N:1 multiplexer.
module mux #(
    parameter  int unsigned Width = 1,
    parameter  int unsigned Num   = 2,
    localparam int unsigned SelW  = (Num > 1) ? $clog2(Num) : 1
) (
    input  logic [Width-1:0] data [Num],
    input  logic [SelW-1:0]  sel,
    output logic [Width-1:0] y
);
    always_comb begin
        y = '0;
        for (int unsigned i = 0; i < Num; i++) begin
            if (sel == SelW'(i)) y = data[i];
        end
    end
endmodule

// File: rtl/pipeline_skid_buffer.sv
// Two-entry valid/ready pipeline stage with registered ready toward the producer.
module pipeline_skid_buffer #(
    parameter int unsigned DataWidth = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    input  logic [DataWidth-1:0] data_i,
    output logic                 ready_o,
    output logic                 valid_o,
    output logic [DataWidth-1:0] data_o,
    input  logic                 ready_i
);
    logic                 out_valid_q;
    logic [DataWidth-1:0] out_data_q;
    logic                 skid_valid_q;
    logic [DataWidth-1:0] skid_data_q;

    assign ready_o = !skid_valid_q;
    assign valid_o = out_valid_q;
    assign data_o  = out_data_q;

    // A stalled output parks the incoming beat in the skid slot, which then drops ready_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else if (!skid_valid_q) begin
            if (!out_valid_q || ready_i) begin
                out_valid_q <= valid_i;
                out_data_q  <= data_i;
            end else if (valid_i) begin
                skid_valid_q <= 1'b1;
                skid_data_q  <= data_i;
            end
        end else if (ready_i) begin
            out_data_q   <= skid_data_q;
            skid_valid_q <= 1'b0;
        end
    end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter; the pointer moves past the index reported on upd.
module rr_arbiter #(
    parameter  int unsigned Width = 2,
    localparam int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] req,
    input  logic             upd,
    input  logic [IdxW-1:0]  upd_idx,
    output logic             grant_valid,
    output logic [IdxW-1:0]  grant_idx
);
    logic [IdxW-1:0] ptr_q;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 0; i < Width; i++) begin
            if (!grant_valid && req[(32'(ptr_q) + i) % Width]) begin
                grant_valid = 1'b1;
                grant_idx   = IdxW'((32'(ptr_q) + i) % Width);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (upd) begin
            ptr_q <= IdxW'((32'(upd_idx) + 1) % Width);
        end
    end
endmodule

// File: rtl/axi_ic_b.sv
// AXI interconnect B-channel router: buffers slave responses, steers them to the master
// encoded in the upper bid half, and restores the master-side ID.
module axi_ic_b
    import axi_ic_pkg::*;
#(
    parameter  int unsigned NumMasters = 2,
    parameter  int unsigned NumSlaves  = 2,
    localparam int unsigned GrantWidth = (NumSlaves > 1) ? $clog2(NumSlaves) : 1
) (
    input  logic                  aclk,
    input  logic                  rst_n,
    axi_b_if.master               axi_m_b [NumSlaves],
    axi_b_if.slave                axi_sl_b [NumMasters],
    output logic [GrantWidth-1:0] b_grant_o [NumMasters],
    output logic                  b_route_err_o
);
    logic [NumSlaves-1:0]   buf_valid;
    logic [NumSlaves-1:0]   buf_ready;
    logic [NumSlaves-1:0]   oor;
    b_payload_t             buf_pl     [NumSlaves];
    logic [ID_W_HALF-1:0]   tgt        [NumSlaves];
    logic [B_PAYLOAD_W-1:0] route_data [NumSlaves];
    logic [NumSlaves-1:0]   rdy_m      [NumMasters];
    logic                   err_q;

    for (genvar s = 0; s < NumSlaves; s++) begin : g_slave
        b_payload_t in_pl;

        assign in_pl = '{bresp: axi_m_b[s].bresp, bid: axi_m_b[s].bid};

        pipeline_skid_buffer #(.DataWidth(B_PAYLOAD_W)) u_skid (
            .clk     (aclk),
            .rst_n   (rst_n),
            .valid_i (axi_m_b[s].bvalid),
            .data_i  (in_pl),
            .ready_o (axi_m_b[s].bready),
            .valid_o (buf_valid[s]),
            .data_o  (buf_pl[s]),
            .ready_i (buf_ready[s])
        );

        // Upper ID half carries the master index; the lower half is the master's own ID.
        assign tgt[s]        = buf_pl[s].bid[ID_W_WIDTH-1 -: ID_W_HALF];
        assign oor[s]        = 32'(tgt[s]) >= NumMasters;
        assign route_data[s] = {buf_pl[s].bresp, ID_W_HALF'(0), buf_pl[s].bid[ID_W_HALF-1:0]};
    end

    for (genvar m = 0; m < NumMasters; m++) begin : g_master
        logic [NumSlaves-1:0] req;

        always_comb begin
            req = '0;
            for (int unsigned s = 0; s < NumSlaves; s++) begin
                req[s] = buf_valid[s] && (tgt[s] == ID_W_HALF'(m));
            end
        end

        axi_ic_b_route #(.NumSlaves(NumSlaves), .GrantWidth(GrantWidth)) u_route (
            .clk    (aclk),
            .rst_n  (rst_n),
            .req    (req),
            .data   (route_data),
            .bvalid (axi_sl_b[m].bvalid),
            .bid    (axi_sl_b[m].bid),
            .bresp  (axi_sl_b[m].bresp),
            .bready (axi_sl_b[m].bready),
            .ready  (rdy_m[m]),
            .grant  (b_grant_o[m])
        );
    end

    // Unroutable responses drain immediately; otherwise the granting master supplies ready.
    always_comb begin
        buf_ready = buf_valid & oor;
        for (int unsigned m = 0; m < NumMasters; m++) begin
            buf_ready = buf_ready | rdy_m[m];
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= |(buf_valid & oor);
        end
    end

    assign b_route_err_o = err_q;
endmodule

// File: tb/tb_axi_ic_b.sv
// Directed bench for axi_ic_b with three masters and two slaves.
module tb_axi_ic_b;
    import axi_ic_pkg::*;

    localparam int unsigned NM = 3;
    localparam int unsigned NS = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axi_b_if s_if [NS] ();
    axi_b_if m_if [NM] ();

    logic [0:0]    grant [NM];
    logic          err;
    logic [NS-1:0] s_valid;
    logic [NS-1:0] s_ready;
    logic [7:0]    s_bid  [NS];
    logic [1:0]    s_resp [NS];
    logic [NM-1:0] m_valid;
    logic [NM-1:0] m_ready;
    logic [7:0]    m_bid  [NM];
    logic [1:0]    m_resp [NM];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < NS; g++) begin : g_s
        assign s_if[g].bvalid = s_valid[g];
        assign s_if[g].bid    = s_bid[g];
        assign s_if[g].bresp  = s_resp[g];
        assign s_ready[g]     = s_if[g].bready;
    end

    for (genvar g = 0; g < NM; g++) begin : g_m
        assign m_if[g].bready = m_ready[g];
        assign m_valid[g]     = m_if[g].bvalid;
        assign m_bid[g]       = m_if[g].bid;
        assign m_resp[g]      = m_if[g].bresp;
    end

    axi_ic_b #(.NumMasters(NM), .NumSlaves(NS)) dut (
        .aclk          (clk),
        .rst_n         (rst_n),
        .axi_m_b       (s_if),
        .axi_sl_b      (m_if),
        .b_grant_o     (grant),
        .b_route_err_o (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic put(input int s, input logic [7:0] id, input logic [1:0] r);
        s_valid[s] = 1'b1;
        s_bid[s]   = id;
        s_resp[s]  = r;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        s_valid = '0;
        s_bid   = '{8'h00, 8'h00};
        s_resp  = '{2'b00, 2'b00};
        m_ready = '1;
        #2;
        total++; if (m_valid !== 3'b000) begin bad++; $display("FAIL reset_bvalid got=%b want=000", m_valid); end
        total++; if (m_bid[0] !== 8'h00) begin bad++; $display("FAIL reset_bid got=%h want=00", m_bid[0]); end
        total++; if (m_resp[0] !== 2'b00) begin bad++; $display("FAIL reset_bresp got=%b want=00", m_resp[0]); end
        total++; if (s_ready !== 2'b11) begin bad++; $display("FAIL reset_bready got=%b want=11", s_ready); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        total++; if (grant[0] !== 1'b0) begin bad++; $display("FAIL reset_grant got=%b want=0", grant[0]); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        sample();
        total++; if (s_ready !== 2'b11) begin bad++; $display("FAIL post_reset_bready got=%b want=11", s_ready); end
    endtask

    task automatic test_single();
        tick();
        put(1, 8'h13, BRESP_OKAY);
        sample();
        total++; if (s_ready[1] !== 1'b1) begin bad++; $display("FAIL single_accept got=%b want=1", s_ready[1]); end
        total++; if (m_valid !== 3'b000) begin bad++; $display("FAIL single_early got=%b want=000", m_valid); end
        tick();
        s_valid = '0;
        sample();
        total++; if (m_valid !== 3'b010) begin bad++; $display("FAIL single_bvalid got=%b want=010", m_valid); end
        total++; if (m_bid[1] !== 8'h03) begin bad++; $display("FAIL single_bid got=%h want=03", m_bid[1]); end
        total++; if (m_resp[1] !== 2'b00) begin bad++; $display("FAIL single_bresp got=%b want=00", m_resp[1]); end
        total++; if (grant[1] !== 1'b1) begin bad++; $display("FAIL single_grant got=%b want=1", grant[1]); end
        tick();
        sample();
        total++; if (m_valid !== 3'b000) begin bad++; $display("FAIL single_done got=%b want=000", m_valid); end
    endtask

    task automatic test_contention();
        // Round 1: pointer at slave 0.
        tick();
        put(0, 8'h05, BRESP_EXOKAY);
        put(1, 8'h0A, BRESP_SLVERR);
        tick();
        s_valid = '0;
        sample();
        total++; if (m_valid !== 3'b001) begin bad++; $display("FAIL cont1_first_valid got=%b want=001", m_valid); end
        total++; if (m_bid[0] !== 8'h05) begin bad++; $display("FAIL cont1_first_bid got=%h want=05", m_bid[0]); end
        total++; if (m_resp[0] !== 2'b01) begin bad++; $display("FAIL cont1_first_bresp got=%b want=01", m_resp[0]); end
        tick();
        sample();
        total++; if (m_valid !== 3'b001) begin bad++; $display("FAIL cont1_second_valid got=%b want=001", m_valid); end
        total++; if (m_bid[0] !== 8'h0A) begin bad++; $display("FAIL cont1_second_bid got=%h want=0a", m_bid[0]); end
        total++; if (grant[0] !== 1'b1) begin bad++; $display("FAIL cont1_second_grant got=%b want=1", grant[0]); end
        tick();
        sample();
        total++; if (m_valid !== 3'b000) begin bad++; $display("FAIL cont1_drain got=%b want=000", m_valid); end
        // Lone slave-0 response moves the pointer to slave 1.
        put(0, 8'h01, BRESP_OKAY);
        tick();
        s_valid = '0;
        sample();
        total++; if (m_bid[0] !== 8'h01 || m_valid !== 3'b001) begin bad++; $display("FAIL lone_bid got=%h/%b want=01/001", m_bid[0], m_valid); end
        // Round 2: slave 1 now wins first.
        tick();
        put(0, 8'h05, BRESP_EXOKAY);
        put(1, 8'h0A, BRESP_SLVERR);
        tick();
        s_valid = '0;
        sample();
        total++; if (m_bid[0] !== 8'h0A) begin bad++; $display("FAIL cont2_first_bid got=%h want=0a", m_bid[0]); end
        total++; if (grant[0] !== 1'b1) begin bad++; $display("FAIL cont2_first_grant got=%b want=1", grant[0]); end
        tick();
        sample();
        total++; if (m_bid[0] !== 8'h05) begin bad++; $display("FAIL cont2_second_bid got=%h want=05", m_bid[0]); end
        total++; if (m_valid !== 3'b001) begin bad++; $display("FAIL cont2_second_valid got=%b want=001", m_valid); end
        tick();
        sample();
        total++; if (m_valid !== 3'b000) begin bad++; $display("FAIL cont2_drain got=%b want=000", m_valid); end
    endtask

    task automatic test_backpressure();
        // Pointer favours slave 1, so the held grant on slave 0 must come from the lock.
        tick();
        m_ready[0] = 1'b0;
        put(0, 8'h07, BRESP_SLVERR);
        tick();
        s_valid = '0;
        put(1, 8'h0C, BRESP_OKAY);
        for (int i = 0; i < 5; i++) begin
            sample();
            total++; if (m_valid[0] !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got=%b want=1", i, m_valid[0]); end
            total++; if (m_bid[0] !== 8'h07) begin bad++; $display("FAIL bp_hold_bid[%0d] got=%h want=07", i, m_bid[0]); end
            total++; if (m_resp[0] !== 2'b10) begin bad++; $display("FAIL bp_hold_bresp[%0d] got=%b want=10", i, m_resp[0]); end
            total++; if (grant[0] !== 1'b0) begin bad++; $display("FAIL bp_hold_grant[%0d] got=%b want=0", i, grant[0]); end
            tick();
            s_valid = '0;
        end
        m_ready[0] = 1'b1;
        sample();
        total++; if (m_bid[0] !== 8'h07 || m_valid[0] !== 1'b1) begin bad++; $display("FAIL bp_release got=%h/%b want=07/1", m_bid[0], m_valid[0]); end
        tick();
        sample();
        total++; if (m_bid[0] !== 8'h0C || m_resp[0] !== 2'b00) begin bad++; $display("FAIL bp_waiter got=%h/%b want=0c/00", m_bid[0], m_resp[0]); end
        total++; if (grant[0] !== 1'b1) begin bad++; $display("FAIL bp_waiter_grant got=%b want=1", grant[0]); end
        tick();
        sample();
        total++; if (m_valid !== 3'b000) begin bad++; $display("FAIL bp_drain got=%b want=000", m_valid); end
    endtask

    task automatic test_out_of_range();
        int pulses = 0;
        int seen   = 0;
        tick();
        put(0, 8'h32, BRESP_OKAY);
        sample();
        total++; if (s_ready[0] !== 1'b1) begin bad++; $display("FAIL oor_accept got=%b want=1", s_ready[0]); end
        tick();
        s_valid = '0;
        for (int i = 0; i < 4; i++) begin
            sample();
            if (err === 1'b1) pulses++;
            if (m_valid !== 3'b000) seen++;
            tick();
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL oor_err_pulses got=%0d want=1", pulses); end
        total++; if (seen !== 0) begin bad++; $display("FAIL oor_forwarded got=%0d want=0", seen); end
        sample();
        total++; if (s_ready[0] !== 1'b1) begin bad++; $display("FAIL oor_recover got=%b want=1", s_ready[0]); end
    endtask

    task automatic test_parallel();
        tick();
        put(0, 8'h1B, BRESP_EXOKAY);
        put(1, 8'h04, BRESP_DECERR);
        tick();
        s_valid = '0;
        sample();
        total++; if (m_valid !== 3'b011) begin bad++; $display("FAIL par_valid got=%b want=011", m_valid); end
        total++; if (m_bid[1] !== 8'h0B || m_resp[1] !== 2'b01) begin bad++; $display("FAIL par_m1 got=%h/%b want=0b/01", m_bid[1], m_resp[1]); end
        total++; if (m_bid[0] !== 8'h04 || m_resp[0] !== 2'b11) begin bad++; $display("FAIL par_m0 got=%h/%b want=04/11", m_bid[0], m_resp[0]); end
        total++; if (grant[1] !== 1'b0 || grant[0] !== 1'b1) begin bad++; $display("FAIL par_grant got=%b%b want=01", grant[1], grant[0]); end
        tick();
        sample();
        total++; if (m_valid !== 3'b000) begin bad++; $display("FAIL par_drain got=%b want=000", m_valid); end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        tick();
        m_ready[0] = 1'b0;
        put(0, 8'h06, BRESP_SLVERR);
        tick();
        s_valid = '0;
        sample();
        total++; if (m_valid[0] !== 1'b1) begin bad++; $display("FAIL rm_stalled got=%b want=1", m_valid[0]); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (m_valid !== 3'b000) begin bad++; $display("FAIL rm_async_valid got=%b want=000", m_valid); end
        total++; if (m_bid[0] !== 8'h00) begin bad++; $display("FAIL rm_async_bid got=%h want=00", m_bid[0]); end
        @(negedge clk);
        #2 rst_n = 1'b1;
        m_ready = '1;
        for (int i = 0; i < 4; i++) begin
            tick();
            sample();
            if (m_valid !== 3'b000) stale++;
        end
        total++; if (stale !== 0) begin bad++; $display("FAIL rm_stale got=%0d want=0", stale); end
        total++; if (s_ready !== 2'b11) begin bad++; $display("FAIL rm_bready got=%b want=11", s_ready); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_out_of_range();
        test_parallel();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
